// File: rtl/mem_pkg.sv
// Shared encodings for the memory arbiter: FSM states, grant owner and access lengths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [1:0] LEN_BYTE   = 2'b00;
    localparam logic [1:0] LEN_HALF   = 2'b01;
    localparam logic [1:0] LEN_WORD   = 2'b10;
    localparam logic [1:0] LEN_DOUBLE = 2'b11;

endpackage

// File: rtl/arb_timer.sv
// BUSY-cycle watchdog: counts enabled cycles since clear and flags the cycle
// in which the count reaches TIMEOUT.
module arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds completed BUSY cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single RAM port with
// round-robin tie-break and a BUSY-cycle timeout.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned PLEN    = 64,
    parameter int unsigned DLEN    = 64,
    parameter int unsigned ILEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_req,
    input  logic [PLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [ILEN-1:0] i_data,
    output logic            i_err,

    input  logic            d_req,
    input  logic [PLEN-1:0] d_addr,
    input  logic [DLEN-1:0] d_wdata,
    input  logic [1:0]      d_len,
    input  logic            d_we,
    output logic            d_ack,
    output logic [DLEN-1:0] d_rdata,
    output logic            d_err,

    output logic            m_req,
    output logic [PLEN-1:0] m_addr,
    output logic [DLEN-1:0] m_wdata,
    output logic [1:0]      m_len,
    output logic            m_we,
    output logic            m_re,
    input  logic            m_ack,
    input  logic [DLEN-1:0] m_rdata
);

    state_t state;
    grant_t grant;
    grant_t last_grant;
    grant_t pick;
    logic   expired;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .enable  (state == BUSY),
        .expired (expired)
    );

    always_comb begin
        pick = GNT_I;
        if (i_req && d_req) begin
            pick = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            pick = GNT_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= GNT_I;
            last_grant <= GNT_I;
            m_req      <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_len      <= '0;
            m_we       <= 1'b0;
            m_re       <= 1'b0;
            i_ack      <= 1'b0;
            i_data     <= '0;
            i_err      <= 1'b0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        m_req      <= 1'b1;
                        state      <= BUSY;
                        if (pick == GNT_D) begin
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_len   <= d_len;
                            m_we    <= d_we;
                            m_re    <= ~d_we;
                        end else begin
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_len   <= LEN_WORD;
                            m_we    <= 1'b0;
                            m_re    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // m_ack wins over an expiry in the same cycle
                    if (m_ack || expired) begin
                        m_req <= 1'b0;
                        state <= RESP;
                        if (grant == GNT_I) begin
                            i_ack  <= 1'b1;
                            i_err  <= ~m_ack;
                            i_data <= m_ack ? m_rdata[ILEN-1:0] : '0;
                        end else begin
                            d_ack <= 1'b1;
                            d_err <= ~m_ack;
                            if (m_re) begin
                                d_rdata <= m_ack ? m_rdata : '0;
                            end
                        end
                    end
                end
                RESP: begin
                    i_ack <= 1'b0;
                    i_err <= 1'b0;
                    d_ack <= 1'b0;
                    d_err <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    m_req <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/responses are queued by the
// stimulus and checked by a monitor whenever the DUT raises m_req or an ack.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_ack;
    logic [31:0] i_data;
    logic        i_err;
    logic        d_req;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [1:0]  d_len;
    logic        d_we;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_len;
    logic        m_we;
    logic        m_re;
    logic        m_ack;
    logic [63:0] m_rdata;

    mem_arbiter #(.PLEN(64), .DLEN(64), .ILEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_len(d_len), .d_we(d_we),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_len(m_len), .m_we(m_we),
        .m_re(m_re), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  len;
        logic        we;
        logic        re;
        int          bcyc;   // expected BUSY length, -1 when the transfer is aborted
    } gexp_t;

    typedef struct {
        logic        is_d;
        logic [63:0] data;
        logic        err;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int n_chk = 0;
    int n_fail = 0;
    int ack_count = 0;
    int ack_delay = 0;     // BUSY cycle in which the memory acks; 0 = never
    logic stray = 1'b0;    // drive m_ack while no transfer is in flight

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic gexp_t g(input logic [63:0] a, input logic [63:0] w, input logic [1:0] l,
                                input logic we, input logic re, input int b);
        gexp_t e;
        e.addr = a; e.wdata = w; e.len = l; e.we = we; e.re = re; e.bcyc = b;
        return e;
    endfunction

    function automatic rexp_t r(input logic is_d, input logic [63:0] dat, input logic err);
        rexp_t e;
        e.is_d = is_d; e.data = dat; e.err = err;
        return e;
    endfunction

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (ack_count < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_ack_seen"}, 64'(ack_count >= target), 64'd1);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ctl"}, {56'd0, m_req, m_we, m_re, i_ack, i_err, d_ack, d_err, 1'b0}, 64'd0);
        chk({name, "_m_len"}, 64'(m_len), 64'd0);
        chk({name, "_m_addr"}, m_addr, 64'd0);
        chk({name, "_m_wdata"}, m_wdata, 64'd0);
        chk({name, "_i_data"}, 64'(i_data), 64'd0);
        chk({name, "_d_rdata"}, d_rdata, 64'd0);
    endtask

    // memory model: acks in the ack_delay-th BUSY cycle
    initial begin
        int bc = 0;
        m_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (m_req && rst_n) begin
                bc++;
                m_ack = (ack_delay != 0) && (bc == ack_delay);
            end else begin
                bc = 0;
                m_ack = stray;
            end
        end
    end

    // monitor
    initial begin
        gexp_t cur;
        rexp_t e;
        logic  prev_mreq = 1'b0;
        logic  prev_iack = 1'b0;
        logic  prev_dack = 1'b0;
        int    busy = 0;
        cur = g(0, 0, 0, 0, 0, -1);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_mreq = 1'b0; prev_iack = 1'b0; prev_dack = 1'b0; busy = 0;
                continue;
            end
            if (m_req && !prev_mreq) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", {63'd0, m_req}, 64'd0);
                end else begin
                    cur = gq.pop_front();
                    chk("m_addr", m_addr, cur.addr);
                    chk("m_wdata", m_wdata, cur.wdata);
                    chk("m_len", 64'(m_len), 64'(cur.len));
                    chk("m_we_re", {62'd0, m_we, m_re}, {62'd0, cur.we, cur.re});
                end
                busy = 0;
            end
            if (m_req) begin
                busy++;
                chk("m_attr_stable", 64'(m_addr == cur.addr && m_wdata == cur.wdata &&
                    m_len == cur.len && m_we == cur.we && m_re == cur.re), 64'd1);
            end
            if (!m_req && prev_mreq && cur.bcyc >= 0) begin
                chk("busy_cycles", 64'(busy), 64'(cur.bcyc));
            end
            if (i_ack || d_ack) begin
                ack_count++;
                chk("ack_single_owner", 64'(i_ack && d_ack), 64'd0);
                chk("ack_pulse_width", {62'd0, prev_iack & i_ack, prev_dack & d_ack}, 64'd0);
                chk("m_req_low_in_resp", 64'(m_req), 64'd0);
                if (rq.size() == 0) begin
                    chk("unexpected_ack", {62'd0, i_ack, d_ack}, 64'd0);
                end else begin
                    e = rq.pop_front();
                    chk("ack_source", {62'd0, i_ack, d_ack}, {62'd0, ~e.is_d, e.is_d});
                    if (e.is_d) begin
                        chk("d_rdata", d_rdata, e.data);
                        chk("d_err", 64'(d_err), 64'(e.err));
                        chk("i_err_idle", 64'(i_err), 64'd0);
                    end else begin
                        chk("i_data", 64'(i_data), e.data);
                        chk("i_err", 64'(i_err), 64'(e.err));
                        chk("d_err_idle", 64'(d_err), 64'd0);
                    end
                end
            end
            prev_mreq = m_req;
            prev_iack = i_ack;
            prev_dack = d_ack;
        end
    end

    // stimulus
    initial begin
        rst_n   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 64'h40;
        d_req   = 1'b1;
        d_addr  = 64'h80;
        d_wdata = 64'hA1A2_A3A4_A5A6_A7A8;
        d_len   = 2'b11;
        d_we    = 1'b0;
        m_rdata = 64'hCAFE_0000_1234_5678;
        ack_delay = 1;

        // tie from reset: D, I, D, I
        for (int k = 0; k < 2; k++) begin
            gq.push_back(g(64'h80, 64'hA1A2_A3A4_A5A6_A7A8, 2'b11, 1'b0, 1'b1, 1));
            gq.push_back(g(64'h40, 64'd0, 2'b10, 1'b0, 1'b1, 1));
            rq.push_back(r(1'b1, 64'hCAFE_0000_1234_5678, 1'b0));
            rq.push_back(r(1'b0, 64'h1234_5678, 1'b0));
        end
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("grant_after_release", 64'(m_req), 64'd1);
        wait_acks(4, "tie");
        i_req = 1'b0;
        d_req = 1'b0;

        // single instruction fetch, ack in 3rd BUSY cycle
        @(negedge clk);
        m_rdata = 64'h0000_0000_DEAD_BEEF;
        ack_delay = 3;
        i_addr = 64'h1000;
        gq.push_back(g(64'h1000, 64'd0, 2'b10, 1'b0, 1'b1, 3));
        rq.push_back(r(1'b0, 64'hDEAD_BEEF, 1'b0));
        i_req = 1'b1;
        wait_acks(5, "fetch");
        i_req = 1'b0;

        // write keeps previous d_rdata
        @(negedge clk);
        m_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
        ack_delay = 1;
        d_we = 1'b1;
        d_addr = 64'h2008;
        d_wdata = 64'h1122_3344_5566_7788;
        d_len = 2'b11;
        gq.push_back(g(64'h2008, 64'h1122_3344_5566_7788, 2'b11, 1'b1, 1'b0, 1));
        rq.push_back(r(1'b1, 64'hCAFE_0000_1234_5678, 1'b0));
        d_req = 1'b1;
        wait_acks(6, "write");
        d_req = 1'b0;

        // m_ack with nothing in flight is ignored
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("stray_ack_ignored", 64'(ack_count), 64'd6);
        chk("stray_no_grant", 64'(m_req), 64'd0);

        // timeout: no ack, read data forced to zero, err set
        d_we = 1'b0;
        d_addr = 64'h3000;
        d_len = 2'b01;
        m_rdata = 64'h5555_5555_5555_5555;
        ack_delay = 0;
        gq.push_back(g(64'h3000, 64'h1122_3344_5566_7788, 2'b01, 1'b0, 1'b1, 4));
        rq.push_back(r(1'b1, 64'd0, 1'b1));
        d_req = 1'b1;
        wait_acks(7, "timeout");
        d_req = 1'b0;

        // ack in the same cycle the timeout would fire: normal completion
        @(negedge clk);
        d_addr = 64'h3010;
        m_rdata = 64'h0123_4567_89AB_CDEF;
        ack_delay = 4;
        gq.push_back(g(64'h3010, 64'h1122_3344_5566_7788, 2'b01, 1'b0, 1'b1, 4));
        rq.push_back(r(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0));
        d_req = 1'b1;
        wait_acks(8, "ack_at_limit");
        d_req = 1'b0;

        // asynchronous reset in the middle of BUSY
        @(negedge clk);
        i_addr = 64'h5000;
        ack_delay = 0;
        gq.push_back(g(64'h5000, 64'd0, 2'b10, 1'b0, 1'b1, -1));
        i_req = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("busy_before_reset", 64'(m_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        @(negedge clk);
        ack_delay = 2;
        m_rdata = 64'h0000_0000_600D_F00D;
        gq.push_back(g(64'h5000, 64'd0, 2'b10, 1'b0, 1'b1, 2));
        rq.push_back(r(1'b0, 64'h600D_F00D, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        wait_acks(9, "after_reset");
        i_req = 1'b0;

        repeat (5) @(negedge clk);
        chk("grants_consumed", 64'(gq.size()), 64'd0);
        chk("responses_consumed", 64'(rq.size()), 64'd0);
        chk("total_acks", 64'(ack_count), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
